sdio_cmd_sequencer: RTL and testbench
=====================================

# sdio_cmd_sequencer

Descriptor-driven sequencer that sits between the uDMA SDIO register file and `sdio_txrx`. It queues up to `DEPTH` command/transfer descriptors and issues them one at a time, generating the clear-status, start and configuration signals. Per descriptor it waits for end-of-transfer, applies a timeout, and returns response data and status. On error it can flush the queue, so software can post a whole card-init or multi-block sequence in one go.

## Interface
Parameters:
- `DEPTH`, 4: descriptor FIFO entries, power of two, 2..16.
- `TIMEOUT_W`, 20: width of the per-descriptor timeout counter.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `desc_valid_i` in 1 / `desc_ready_o` out 1: descriptor push handshake.
- `desc_op_i` in 6, `desc_arg_i` in 32, `desc_rsp_type_i` in 3: command fields.
- `desc_data_en_i` in 1, `desc_rwn_i` in 1, `desc_quad_i` in 1, `desc_block_size_i` in 10, `desc_block_num_i` in 8: data fields.
- `timeout_i` in TIMEOUT_W: cycles allowed in WAIT; 0 disables the timeout.
- `abort_on_err_i` in 1: flush the queue on error.
- `clr_err_i` in 1: clears `err_o` and `timeout_o`.
- `clr_stat_o` out 1, `cmd_start_o` out 1: pulses to txrx.
- `cmd_op_o` out 6, `cmd_arg_o` out 32, `cmd_rsp_type_o` out 3: to txrx.
- `data_en_o`, `data_rwn_o`, `data_quad_o` out 1 each; `data_block_size_o` out 10; `data_block_num_o` out 8: to txrx.
- `eot_i` in 1, `status_i` in 16, `rsp_data_i` in 128: from txrx.
- `rsp_valid_o` out 1, `rsp_data_o` out 128, `rsp_status_o` out 16: per-descriptor result.
- `busy_o` out 1, `err_o` out 1, `timeout_o` out 1, `level_o` out $clog2(DEPTH)+1: status.

## Operation
- The FIFO stores every `desc_*` field.
- `desc_ready_o` = not full and not in a flush cycle.
- A push is accepted when `desc_valid_i & desc_ready_o`.
- A push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- States: IDLE, CLR, START, WAIT, DONE.
- IDLE:
  - All `cmd_*`/`data_*` outputs are 0.
  - FIFO non-empty → CLR.
- CLR (1 cycle):
  - Head fields are registered onto the `cmd_*`/`data_*` outputs.
  - `clr_stat_o`=1.
  - Timeout counter = 0.
  - → START.
  - The config outputs are held stable from CLR until DONE completes. `sdio_txrx` registers `data_en` one cycle before it needs it at `cmd_start`, which is why config leads start by one cycle.
- START (1 cycle): `cmd_start_o`=1 → WAIT.
- WAIT:
  - `eot_i`=1 → capture `rsp_data_i` and `status_i` → DONE with result OK, or ERR if `status_i[5:0]!=0` or `status_i[13:8]!=0`.
  - Otherwise, if `timeout_i!=0` and counter==`timeout_i` → DONE with result ERR; set `timeout_o`; `rsp_status_o`=16'hFFFF.
  - Otherwise counter +1, saturating at all-ones.
  - `eot_i` and timeout in the same cycle → `eot_i` wins.
  - `eot_i` outside WAIT is ignored.
- DONE (1 cycle):
  - `rsp_valid_o`=1 and the head entry is popped.
  - If ERR: `err_o` is set (sticky).
  - If ERR and `abort_on_err_i`: all remaining entries are flushed (level → 0) and `desc_ready_o`=0 this cycle.
  - → IDLE.
  - The `cmd_*`/`data_*` outputs return to 0 in the next cycle.
- `rsp_data_o`/`rsp_status_o` hold their last captured values until the next capture.
- `clr_err_i` clears `err_o` and `timeout_o` next cycle. If it coincides with a new error, set wins.
- `busy_o` = state != IDLE or FIFO non-empty.
- `level_o` counts queued entries, including the executing head until its pop.

## Timing
- Reset value of all outputs is 0, except `desc_ready_o`=1. State IDLE, FIFO empty, flags clear.
- Reset mid-transfer aborts immediately. The txrx is reset by the same domain.
- Push at cycle N into an empty idle FIFO:
  - CLR at N+1 (`clr_stat_o`).
  - START at N+2 (`cmd_start_o`).
  - WAIT from N+3.
- Eot at cycle E: `rsp_valid_o` at E+1; the next descriptor's CLR at E+2.
- Timeout `T`: WAIT lasts T+1 cycles with no eot; DONE follows.
- Fields accepted as `desc_*` appear on the txrx outputs unchanged. No width conversion; `block_num` keeps the txrx convention that 0 = single block.

## Test plan
- Single command: push op=8, arg=0x1AA, rsp=1, data_en=0; eot 20 cycles after start, status=0 → `clr_stat`, `cmd_start` one cycle apart; `rsp_valid` with captured `rsp_data`; `err_o`=0; level 1→0.
- Back-to-back: push 3 descriptors, read 4 blocks of 512 B with quad=1 → three CLR/START/WAIT/DONE sequences in order; `data_en_o`=1 a cycle before each `cmd_start_o`; exactly 3 `rsp_valid` pulses.
- Error with abort: 3 queued, first eot with `status_i`=16'h0100, `abort_on_err_i`=1 → `err_o`=1, level=0 after DONE, no further `cmd_start`; `clr_err_i` clears `err_o`.
- Timeout: `timeout_i`=5, no eot → DONE 6 cycles into WAIT; `timeout_o`=1, `rsp_status_o`=16'hFFFF. Repeat with eot on the 6th WAIT cycle → OK result, no timeout.
- FIFO full: DEPTH=4, push 5 while stalled → 5th held with `desc_ready_o`=0 until the first DONE pop, then accepted the next cycle.
- Reset during WAIT: assert `rst_i` for 1 cycle → all outputs 0, `desc_ready_o`=1, level 0; a stale eot afterwards produces no `rsp_valid`.

Source files
------------

// File: rtl/sdio_cmd_sequencer_if.sv
// sdio_cmd_sequencer_if: descriptor push, txrx command/data and result/status signals of the sequencer.
interface sdio_cmd_sequencer_if #(parameter int DEPTH = 4, parameter int TIMEOUT_W = 20);
  logic                       desc_valid_i, desc_ready_o;
  logic [5:0]                 desc_op_i;
  logic [31:0]                desc_arg_i;
  logic [2:0]                 desc_rsp_type_i;
  logic                       desc_data_en_i, desc_rwn_i, desc_quad_i;
  logic [9:0]                 desc_block_size_i;
  logic [7:0]                 desc_block_num_i;
  logic [TIMEOUT_W-1:0]       timeout_i;
  logic                       abort_on_err_i, clr_err_i;
  logic                       clr_stat_o, cmd_start_o;
  logic [5:0]                 cmd_op_o;
  logic [31:0]                cmd_arg_o;
  logic [2:0]                 cmd_rsp_type_o;
  logic                       data_en_o, data_rwn_o, data_quad_o;
  logic [9:0]                 data_block_size_o;
  logic [7:0]                 data_block_num_o;
  logic                       eot_i;
  logic [15:0]                status_i;
  logic [127:0]               rsp_data_i;
  logic                       rsp_valid_o;
  logic [127:0]               rsp_data_o;
  logic [15:0]                rsp_status_o;
  logic                       busy_o, err_o, timeout_o;
  logic [$clog2(DEPTH):0]     level_o;
  modport slave (
    input  desc_valid_i, desc_op_i, desc_arg_i, desc_rsp_type_i, desc_data_en_i, desc_rwn_i,
           desc_quad_i, desc_block_size_i, desc_block_num_i, timeout_i, abort_on_err_i, clr_err_i,
           eot_i, status_i, rsp_data_i,
    output desc_ready_o, clr_stat_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o, data_en_o,
           data_rwn_o, data_quad_o, data_block_size_o, data_block_num_o, rsp_valid_o, rsp_data_o,
           rsp_status_o, busy_o, err_o, timeout_o, level_o
  );
  modport master (
    output desc_valid_i, desc_op_i, desc_arg_i, desc_rsp_type_i, desc_data_en_i, desc_rwn_i,
           desc_quad_i, desc_block_size_i, desc_block_num_i, timeout_i, abort_on_err_i, clr_err_i,
           eot_i, status_i, rsp_data_i,
    input  desc_ready_o, clr_stat_o, cmd_start_o, cmd_op_o, cmd_arg_o, cmd_rsp_type_o, data_en_o,
           data_rwn_o, data_quad_o, data_block_size_o, data_block_num_o, rsp_valid_o, rsp_data_o,
           rsp_status_o, busy_o, err_o, timeout_o, level_o
  );
endinterface

// File: rtl/sdio_cmd_sequencer.sv
// sdio_cmd_sequencer: queues SDIO command/transfer descriptors and issues them one at a time to sdio_txrx.
module sdio_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT_W = 20
) (
  input logic              clk_i,
  input logic              rst_i,
  sdio_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, DONE} state_t;
  state_t               r_state, w_next;
  logic [61:0]          r_mem [DEPTH];
  logic [AW-1:0]        r_wr, r_rd, w_rd_n;
  logic [AW:0]          r_level, w_left;
  logic [61:0]          r_cfg, w_desc, w_head;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_res_err, r_err, r_timeout;
  logic [127:0]         r_rsp_data;
  logic [15:0]          r_rsp_status;
  logic                 w_push, w_pop, w_flush, w_eot, w_tmo, w_bad, w_load;
  assign w_desc = {bus.desc_op_i, bus.desc_arg_i, bus.desc_rsp_type_i, bus.desc_data_en_i,
                   bus.desc_rwn_i, bus.desc_quad_i, bus.desc_block_size_i, bus.desc_block_num_i};
  assign w_pop   = r_state == DONE;
  assign w_flush = w_pop && r_res_err && bus.abort_on_err_i;
  assign bus.desc_ready_o = r_level != (AW+1)'(DEPTH) && !w_flush;
  assign w_push  = bus.desc_valid_i && bus.desc_ready_o;
  assign w_rd_n  = r_rd + AW'(w_pop);
  assign w_left  = r_level - (AW+1)'(w_pop);
  // an empty queue forwards the descriptor being pushed so CLR follows the push directly
  assign w_head  = w_left == '0 ? w_desc : r_mem[w_rd_n];
  assign w_eot   = r_state == WAIT && bus.eot_i;
  assign w_tmo   = r_state == WAIT && !bus.eot_i && bus.timeout_i != '0 && r_cnt == bus.timeout_i;
  assign w_bad   = bus.status_i[5:0] != '0 || bus.status_i[13:8] != '0;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        w_load = !w_flush && (w_left != '0 || w_push);
        w_next = w_load ? CLR : IDLE;
      end
      CLR:     w_next = START;
      START:   w_next = WAIT;
      WAIT:    w_next = (w_eot || w_tmo) ? DONE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) r_state <= rst_i ? IDLE : w_next;
  always_ff @(posedge clk_i) if (w_push) r_mem[r_wr] <= w_desc;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr         <= '0;
      r_rd         <= '0;
      r_level      <= '0;
      r_cfg        <= '0;
      r_cnt        <= '0;
      r_res_err    <= 1'b0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
    end else begin
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= w_flush ? r_wr : w_rd_n;
      r_level <= w_flush ? '0 : w_left + (AW+1)'(w_push);
      r_cfg   <= w_load ? w_head : (w_pop ? '0 : r_cfg);
      r_cnt   <= r_state == CLR ? '0 : (r_state == WAIT && r_cnt != '1 ? r_cnt + TIMEOUT_W'(1) : r_cnt);
      if (w_eot) begin
        r_rsp_data   <= bus.rsp_data_i;
        r_rsp_status <= bus.status_i;
        r_res_err    <= w_bad;
      end else if (w_tmo) begin
        r_rsp_status <= '1;
        r_res_err    <= 1'b1;
      end
      r_err     <= (w_pop && r_res_err) || (r_err && !bus.clr_err_i);
      r_timeout <= w_tmo || (r_timeout && !bus.clr_err_i);
    end
  end
  assign {bus.cmd_op_o, bus.cmd_arg_o, bus.cmd_rsp_type_o, bus.data_en_o, bus.data_rwn_o,
          bus.data_quad_o, bus.data_block_size_o, bus.data_block_num_o} = r_cfg;
  assign bus.clr_stat_o   = r_state == CLR;
  assign bus.cmd_start_o  = r_state == START;
  assign bus.rsp_valid_o  = r_state == DONE;
  assign bus.rsp_data_o   = r_rsp_data;
  assign bus.rsp_status_o = r_rsp_status;
  assign bus.busy_o       = r_state != IDLE || r_level != '0;
  assign bus.err_o        = r_err;
  assign bus.timeout_o    = r_timeout;
  assign bus.level_o      = r_level;
endmodule

// File: tb/tb_sdio_cmd_sequencer.sv
// tb_sdio_cmd_sequencer: randomized descriptor sequences checked against cycle formulas and a descriptor queue model.
module tb_sdio_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int TW    = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sdio_cmd_sequencer_if #(.DEPTH(DEPTH), .TIMEOUT_W(TW)) bus ();
  sdio_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_q[$], start_q[$], rsp_q[$];
  logic [61:0] clr_cfg_q[$], start_cfg_q[$], rsp_cfg_q[$];
  logic [15:0] rsp_st_q[$];
  logic [127:0] rsp_dat_q[$];
  logic [127:0] last_data = '0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [61:0] cfg();
    return {bus.cmd_op_o, bus.cmd_arg_o, bus.cmd_rsp_type_o, bus.data_en_o, bus.data_rwn_o,
            bus.data_quad_o, bus.data_block_size_o, bus.data_block_num_o};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.clr_stat_o) begin clr_q.push_back(cyc); clr_cfg_q.push_back(cfg()); end
    if (bus.cmd_start_o) begin start_q.push_back(cyc); start_cfg_q.push_back(cfg()); end
    if (bus.rsp_valid_o) begin
      rsp_q.push_back(cyc);
      rsp_cfg_q.push_back(cfg());
      rsp_st_q.push_back(bus.rsp_status_o);
      rsp_dat_q.push_back(bus.rsp_data_o);
    end
  endtask
  task automatic flush_log();
    clr_q.delete(); start_q.delete(); rsp_q.delete();
    clr_cfg_q.delete(); start_cfg_q.delete(); rsp_cfg_q.delete();
    rsp_st_q.delete(); rsp_dat_q.delete();
  endtask
  task automatic drive_desc(input logic [61:0] d);
    {bus.desc_op_i, bus.desc_arg_i, bus.desc_rsp_type_i, bus.desc_data_en_i, bus.desc_rwn_i,
     bus.desc_quad_i, bus.desc_block_size_i, bus.desc_block_num_i} = d;
  endtask
  function automatic logic [61:0] rand_desc();
    return 62'({$urandom(), $urandom()});
  endfunction
  function automatic bit reached(input int kind, input int cnt);
    return kind == 0 ? start_q.size() >= cnt : kind == 1 ? rsp_q.size() >= cnt : !bus.busy_o;
  endfunction
  task automatic wait_for(input string tag, input int kind, input int cnt, output bit ok);
    int t = 0;
    while (!reached(kind, cnt) && t < 200) begin tick(); t++; end
    ok = reached(kind, cnt);
    check({tag, "_bound"}, 128'(ok), 128'(1));
  endtask
  task automatic eot(input logic [15:0] st, input logic [127:0] dat);
    bus.eot_i = 1'b1; bus.status_i = st; bus.rsp_data_i = dat;
    tick();
    bus.eot_i = 1'b0;
    last_data = dat;
  endtask
  task automatic clear_err();
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    check("clr_err", bus.err_o, 0);
    check("clr_tmo", bus.timeout_o, 0);
  endtask
  task automatic scenario(input int n, input bit abort, input int tmo);
    logic [61:0] d[$];
    int push_c, nxt_clr, start, dly, tgt, exp_rsp, issued;
    bit ok, exp_err, exp_tmo, bad;
    logic [15:0] st;
    logic [127:0] dat;
    flush_log();
    bus.abort_on_err_i = abort; bus.timeout_i = TW'(tmo);
    exp_err = 0; exp_tmo = 0; issued = 0; push_c = cyc;
    for (int i = 0; i < n; i++) begin
      d.push_back(rand_desc());
      drive_desc(d[i]); bus.desc_valid_i = 1'b1;
      if (i == 0) push_c = cyc;
      tick();
    end
    bus.desc_valid_i = 1'b0;
    nxt_clr = push_c + 1;
    for (int k = 0; k < n; k++) begin
      wait_for("start", 0, k + 1, ok);
      if (!ok) return;
      start = start_q[k]; issued++;
      check("clr_cyc", clr_q[k], nxt_clr);
      check("start_cyc", start, nxt_clr + 1);
      check("clr_cfg", clr_cfg_q[k], d[k]);
      check("start_cfg", start_cfg_q[k], d[k]);
      dly = $urandom_range(2, 9);
      st = 16'($urandom());
      if ($urandom_range(0, 1) == 1) st &= 16'hC0C0;
      dat = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (tmo == 0 || dly <= tmo) begin
        tgt = start + 1 + dly;
        while (cyc < tgt) tick();
        eot(st, dat);
        exp_rsp = tgt + 1; bad = (st & 16'h3F3F) != 0;
      end else begin
        exp_rsp = start + tmo + 2; bad = 1; st = 16'hFFFF; exp_tmo = 1;
      end
      wait_for("rsp", 1, k + 1, ok);
      if (!ok) return;
      check("rsp_cyc", rsp_q[k], exp_rsp);
      check("rsp_status", rsp_st_q[k], st);
      check("rsp_data", rsp_dat_q[k], last_data);
      check("rsp_cfg", rsp_cfg_q[k], d[k]);
      exp_err |= bad;
      nxt_clr = exp_rsp + 1;
      if (bad && abort) break;
    end
    wait_for("idle", 2, 0, ok);
    repeat (3) tick();
    check("starts", start_q.size(), issued);
    check("rsps", rsp_q.size(), issued);
    check("level_end", bus.level_o, 0);
    check("cfg_idle", cfg(), 0);
    check("err", bus.err_o, exp_err);
    check("tmo", bus.timeout_o, exp_tmo);
    clear_err();
  endtask
  task automatic test_abort();
    bit ok;
    flush_log();
    bus.abort_on_err_i = 1'b1; bus.timeout_i = '0;
    for (int i = 0; i < 3; i++) begin drive_desc(rand_desc()); bus.desc_valid_i = 1'b1; tick(); end
    bus.desc_valid_i = 1'b0;
    wait_for("ab_start", 0, 1, ok);
    tick(); tick();
    eot(16'h0100, {4{$urandom()}});
    check("ab_rsp_valid", bus.rsp_valid_o, 1);
    check("ab_status", bus.rsp_status_o, 16'h0100);
    check("ab_ready_flush", bus.desc_ready_o, 0);
    check("ab_level_done", bus.level_o, 3);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    check("ab_level_0", bus.level_o, 0);
    check("ab_err_set_wins", bus.err_o, 1);
    repeat (10) tick();
    check("ab_no_start", start_q.size(), 1);
    check("ab_busy", bus.busy_o, 0);
    clear_err();
  endtask
  task automatic test_full();
    logic [61:0] fd[5];
    bit ok;
    flush_log();
    bus.abort_on_err_i = 1'b0; bus.timeout_i = '0;
    foreach (fd[i]) fd[i] = rand_desc();
    for (int i = 0; i < 4; i++) begin drive_desc(fd[i]); bus.desc_valid_i = 1'b1; tick(); end
    drive_desc(fd[4]);
    check("full_ready", bus.desc_ready_o, 0);
    check("full_level", bus.level_o, 4);
    repeat (3) tick();
    check("full_ready_hold", bus.desc_ready_o, 0);
    eot(16'h0, {4{$urandom()}});
    check("full_done_ready", bus.desc_ready_o, 0);
    check("full_done_valid", bus.rsp_valid_o, 1);
    tick();
    check("full_ready_after_pop", bus.desc_ready_o, 1);
    check("full_level_after_pop", bus.level_o, 3);
    tick();
    bus.desc_valid_i = 1'b0;
    check("full_level_refill", bus.level_o, 4);
    for (int k = 1; k < 5; k++) begin
      wait_for("full_start", 0, k + 1, ok);
      if (!ok) return;
      tick();
      eot(16'h0, {4{$urandom()}});
    end
    wait_for("full_idle", 2, 0, ok);
    for (int i = 0; i < 5; i++) check("full_order", start_cfg_q[i], fd[i]);
    check("full_rsps", rsp_q.size(), 5);
  endtask
  task automatic test_reset();
    bit ok;
    flush_log();
    bus.timeout_i = '0;
    drive_desc(rand_desc()); bus.desc_valid_i = 1'b1;
    tick();
    bus.desc_valid_i = 1'b0;
    wait_for("rst_start", 0, 1, ok);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_data = '0;
    check("mr_ready", bus.desc_ready_o, 1);
    check("mr_level", bus.level_o, 0);
    check("mr_busy", bus.busy_o, 0);
    check("mr_cfg", cfg(), 0);
    check("mr_status", bus.rsp_status_o, 0);
    bus.eot_i = 1'b1; bus.rsp_data_i = {4{$urandom()}}; bus.status_i = 16'h0101;
    tick();
    bus.eot_i = 1'b0;
    repeat (5) tick();
    check("mr_stale_eot", rsp_q.size(), 0);
    check("mr_stale_data", bus.rsp_data_o, last_data);
    check("mr_err", bus.err_o, 0);
  endtask
  initial begin
    bus.desc_valid_i = 1'b0; drive_desc('0);
    bus.timeout_i = '0; bus.abort_on_err_i = 1'b0; bus.clr_err_i = 1'b0;
    bus.eot_i = 1'b0; bus.status_i = '0; bus.rsp_data_i = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", bus.desc_ready_o, 1);
    check("rst_level", bus.level_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_flags", {bus.err_o, bus.timeout_o, bus.rsp_valid_o, bus.clr_stat_o, bus.cmd_start_o}, 0);
    check("rst_cfg", cfg(), 0);
    check("rst_rsp", {bus.rsp_status_o, bus.rsp_data_o}, 0);
    scenario(1, 0, 0);
    scenario(3, 0, 0);
    scenario(1, 0, 5);
    test_abort();
    test_full();
    for (int i = 0; i < 25; i++)
      scenario($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2) == 0 ? 0 : $urandom_range(1, 8));
    test_reset();
    scenario(2, 1, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
